// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, parity mode encodings,
// default bit-period length and a parity helper. Reused by the RX core.
package uart_pkg;

    // 100 MHz system clock / 115200 Bd
    localparam int unsigned CLKS_PER_BIT_DEF = 868;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Parity bit that makes the total count of ones even (PAR_EVEN) or odd (PAR_ODD)
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled and pulses o_tick
// in the terminal-count cycle, then wraps to 0.
//   clk, rstn  : clock, asynchronous active-low reset
//   i_en       : count enable (hold value when low)
//   i_clr      : synchronous clear, wins over enable
//   o_tick     : high in the last cycle of each bit period
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign o_tick = i_en && (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = o_tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit serializer. Accepts one byte per valid/ready handshake and
// sends start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
//   clk, rstn        : clock, asynchronous active-low reset
//   i_tx_en          : transmitter enable
//   i_tx_rst         : synchronous soft reset, aborts any frame
//   i_tx_data        : byte to send
//   i_tx_data_valid  : byte valid pulse
//   o_tx_data_ready  : byte accepted this cycle if valid
//   o_tx_state       : frame in progress
//   o_tx             : serial line, idle high, flop output
//
// state     | meaning
// ----------+--------------------------------------------
// ST_IDLE   | line high, waiting for a byte
// ST_START  | start bit (low) for one bit period
// ST_DATA   | 8 data bits, LSB first, shift each period
// ST_PARITY | parity bit, only when PARITY != PAR_NONE
// ST_STOP   | line high for STOP_BITS bit periods
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_tx_en,
    input  logic       i_tx_rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_data_valid,
    output logic       o_tx_data_ready,
    output logic       o_tx_state,
    output logic       o_tx
);

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       tx_q, tx_d;

    logic       accept;
    logic       baud_tick;

    assign o_tx_data_ready = (state_q == ST_IDLE) && i_tx_en && !i_tx_rst;
    assign accept          = i_tx_data_valid && o_tx_data_ready;
    assign o_tx_state      = (state_q != ST_IDLE);
    assign o_tx            = tx_q;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (state_q != ST_IDLE),
        .i_clr  (accept || i_tx_rst),
        .o_tick (baud_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;

        if (i_tx_rst) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shift_d    = i_tx_data;
                        par_d      = parity_bit(i_tx_data, PARITY);
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        state_d    = ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        if ((STOP_BITS == 2) && (stop_cnt_q == 1'b0)) begin
                            stop_cnt_d = 1'b1;
                        end else begin
                            stop_cnt_d = 1'b0;
                            state_d    = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Line value is derived from the next state so the registered output
        // changes on the same edge as the state, keeping bit edges aligned.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       tx_en;
    logic       tx_rst;
    logic       valid;
    logic [7:0] data;
    logic [2:0] rdy;
    logic [2:0] busy;
    logic [2:0] txl;

    // dut0: 4 clk/bit, no parity, 1 stop; dut1: 4 clk/bit, even, 2 stop; dut2: 5 clk/bit, odd, 1 stop
    uart_tx_core #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rstn(rstn), .i_tx_en(tx_en), .i_tx_rst(tx_rst),
        .i_tx_data(data), .i_tx_data_valid(valid),
        .o_tx_data_ready(rdy[0]), .o_tx_state(busy[0]), .o_tx(txl[0]));

    uart_tx_core #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rstn(rstn), .i_tx_en(tx_en), .i_tx_rst(tx_rst),
        .i_tx_data(data), .i_tx_data_valid(valid),
        .o_tx_data_ready(rdy[1]), .o_tx_state(busy[1]), .o_tx(txl[1]));

    uart_tx_core #(.CLKS_PER_BIT(5), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rstn(rstn), .i_tx_en(tx_en), .i_tx_rst(tx_rst),
        .i_tx_data(data), .i_tx_data_valid(valid),
        .o_tx_data_ready(rdy[2]), .o_tx_state(busy[2]), .o_tx(txl[2]));

    int compared   = 0;
    int mismatched = 0;

    int cpb [3] = '{4, 4, 5};
    int par [3] = '{0, 1, 2};
    int stp [3] = '{1, 2, 1};

    // Reference: the whole frame as a bit list plus a cycle position inside it
    // (-1 when no frame is in flight).
    logic [11:0] fb  [3];
    int          nb  [3];
    int          pos [3];

    task automatic check(input string tag, input int i, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s dut%0d: got %b expected %b at %0t", tag, i, obs, exp, $time);
        end
    endtask

    task automatic build_frame(input int i, input logic [7:0] d);
        int n;
        int ones;
        fb[i] = '0;
        fb[i][0] = 1'b0;
        for (int k = 0; k < 8; k++) fb[i][1 + k] = d[k];
        n = 9;
        ones = $countones(d);
        if (par[i] == 1) begin
            fb[i][n] = (ones % 2 == 1);
            n++;
        end else if (par[i] == 2) begin
            fb[i][n] = (ones % 2 == 0);
            n++;
        end
        for (int s = 0; s < stp[i]; s++) begin
            fb[i][n] = 1'b1;
            n++;
        end
        nb[i] = n;
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!rstn || tx_rst) begin
                pos[i] = -1;
            end else if (pos[i] >= 0) begin
                pos[i]++;
                if (pos[i] == nb[i] * cpb[i]) pos[i] = -1;
            end else if (tx_en && valid) begin
                build_frame(i, data);
                pos[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic exp_tx;
        for (int i = 0; i < 3; i++) begin
            exp_tx = (pos[i] < 0) ? 1'b1 : fb[i][pos[i] / cpb[i]];
            check("tx_line", i, txl[i], exp_tx);
            check("tx_state", i, busy[i], pos[i] >= 0);
            check("ready", i, rdy[i], (pos[i] < 0) && tx_en && !tx_rst);
        end
    endtask

    task automatic cyc(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic send(input logic [7:0] b);
        data  = b;
        valid = 1'b1;
        cyc(1);
        valid = 1'b0;
    endtask

    initial begin
        rstn   = 1'b0;
        tx_en  = 1'b0;
        tx_rst = 1'b0;
        valid  = 1'b0;
        data   = 8'h00;
        for (int i = 0; i < 3; i++) begin
            pos[i] = -1;
            nb[i]  = 10;
            fb[i]  = '1;
        end

        cyc(3);
        rstn = 1'b1;
        cyc(2);
        tx_en = 1'b1;
        cyc(2);

        send(8'hA5);
        cyc(60);
        send(8'h07);
        cyc(60);

        // valid held high: every core restarts in its first idle cycle
        valid = 1'b1;
        for (int c = 0; c < 150; c++) begin
            data = 8'($urandom);
            cyc(1);
        end
        valid = 1'b0;
        cyc(60);

        // byte offered mid-frame must be dropped
        send(8'($urandom));
        cyc(15);
        send(8'($urandom));
        cyc(60);

        // soft reset during data bit 3
        send(8'($urandom));
        cyc(16);
        tx_rst = 1'b1;
        cyc(1);
        tx_rst = 1'b0;
        cyc(3);
        send(8'($urandom));
        cyc(60);

        // enable dropped mid-frame: frame completes, no new accepts
        send(8'($urandom));
        cyc(10);
        tx_en = 1'b0;
        valid = 1'b1;
        cyc(70);
        valid = 1'b0;
        tx_en = 1'b1;
        cyc(2);

        // asynchronous reset mid-frame
        send(8'($urandom));
        cyc(20);
        #2;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            pos[i] = -1;
            check("async_tx", i, txl[i], 1'b1);
            check("async_state", i, busy[i], 1'b0);
        end
        cyc(2);
        rstn = 1'b1;
        cyc(1);
        send(8'h3C);
        cyc(60);

        // random traffic
        for (int c = 0; c < 800; c++) begin
            valid  = ($urandom_range(0, 3) == 0);
            data   = 8'($urandom);
            tx_rst = ($urandom_range(0, 60) == 0);
            tx_en  = ($urandom_range(0, 15) != 0);
            cyc(1);
        end
        valid  = 1'b0;
        tx_rst = 1'b0;
        tx_en  = 1'b1;
        cyc(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
